// File: rtl/res_pkg.sv
// Shared defaults and FSM state type for the result-RAM arbiter.
package res_pkg;
   localparam int RES_ADDR_W   = 14;
   localparam int RES_DATA_W   = 8;
   localparam int RES_MAX_LOCK = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;
endpackage

// File: rtl/res_arb_if.sv
// Bundle of both requester ports plus the RAM-side strobes of the arbiter.
interface res_arb_if import res_pkg::*; #(
   parameter int ADDR_W = RES_ADDR_W,
   parameter int DATA_W = RES_DATA_W
);
   logic              req0, req1, we0, we1, lock0, lock1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1, lock_err;
   logic [DATA_W-1:0] rdata;
   logic              res_rd, res_wr;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] res_do, res_di;

   modport master (
      output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, res_di,
      input  gnt0, gnt1, rvalid0, rvalid1, lock_err, rdata, res_rd, res_wr, res_addr, res_do
   );

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, res_di,
      output gnt0, gnt1, rvalid0, rvalid1, lock_err, rdata, res_rd, res_wr, res_addr, res_do
   );
endinterface

// File: rtl/lock_timer.sv
// Counts consecutive locked cycles; expire_o flags the last permitted locked cycle.
module lock_timer import res_pkg::*; #(
   parameter int MAX_LOCK = RES_MAX_LOCK
)(
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_LOCK - 1);

   logic [CNT_W-1:0] cnt_q;

   assign expire_o = en_i && (cnt_q == TERM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expire_o) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/res_arb.sv
// Two-port arbiter for the result RAM: round-robin in IDLE, optional bounded
// ownership lock per port, one-cycle read return pipeline.
module res_arb import res_pkg::*; #(
   parameter int ADDR_W   = RES_ADDR_W,
   parameter int DATA_W   = RES_DATA_W,
   parameter int MAX_LOCK = RES_MAX_LOCK
)(
   input logic     clk,
   input logic     reset,
   res_arb_if.slave bus
);
   arb_state_e        state_q;
   logic              last_gnt_q;
   logic              rvalid0_q, rvalid1_q;
   logic              gnt0, gnt1, expire, locked_hold;
   logic              rd, wr;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;

   // last_gnt_q = 1 means port 1 was served last, so port 0 wins a tie.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               gnt0 = last_gnt_q;
               gnt1 = ~last_gnt_q;
            end else begin
               gnt0 = bus.req0;
               gnt1 = bus.req1;
            end
         end
         LOCK0:   gnt0 = bus.req0;
         LOCK1:   gnt1 = bus.req1;
         default: ;
      endcase
      if (reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      rd        = 1'b0;
      wr        = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      if (gnt0) begin
         rd        = ~bus.we0;
         wr        = bus.we0;
         addr_mux  = bus.addr0;
         wdata_mux = bus.we0 ? bus.wdata0 : '0;
      end else if (gnt1) begin
         rd        = ~bus.we1;
         wr        = bus.we1;
         addr_mux  = bus.addr1;
         wdata_mux = bus.we1 ? bus.wdata1 : '0;
      end
   end

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.res_rd   = rd;
   assign bus.res_wr   = wr;
   assign bus.res_addr = addr_mux;
   assign bus.res_do   = wdata_mux;
   assign bus.rvalid0  = rvalid0_q;
   assign bus.rvalid1  = rvalid1_q;
   assign bus.rdata    = (rvalid0_q || rvalid1_q) ? bus.res_di : '0;

   // Only a release forced while the owner still asks to hold is an error.
   assign locked_hold  = ((state_q == LOCK0) && bus.lock0) || ((state_q == LOCK1) && bus.lock1);
   assign bus.lock_err = expire && locked_hold;

   lock_timer #(.MAX_LOCK(MAX_LOCK)) u_lock_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (state_q == IDLE),
      .en_i     (state_q != IDLE),
      .expire_o (expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         rvalid0_q <= gnt0 && !bus.we0;
         rvalid1_q <= gnt1 && !bus.we1;
         if (gnt0) begin
            last_gnt_q <= 1'b0;
         end else if (gnt1) begin
            last_gnt_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (gnt0 && bus.lock0) begin
                  state_q <= LOCK0;
               end else if (gnt1 && bus.lock1) begin
                  state_q <= LOCK1;
               end
            end
            LOCK0: begin
               if (!bus.lock0) begin
                  state_q <= IDLE;
               end else if (expire) begin
                  state_q    <= IDLE;
                  last_gnt_q <= 1'b0;
               end
            end
            LOCK1: begin
               if (!bus.lock1) begin
                  state_q <= IDLE;
               end else if (expire) begin
                  state_q    <= IDLE;
                  last_gnt_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_res_arb.sv
// Self-checking bench for res_arb: directed table, corner sequences, random run
// against a behavioural arbitration/memory model.
module tb_res_arb;
   import res_pkg::*;

   localparam int AW   = 14;
   localparam int DW   = 8;
   localparam int MAXL = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   res_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   res_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // RAM behind the arbiter: read data appears the cycle after res_rd.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.res_rd) bus.res_di = mem[bus.res_addr];
      if (bus.res_wr) mem[bus.res_addr] = bus.res_do;
   end

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   int            m_last, m_owner, m_lcycle, m_pend;
   logic [DW-1:0] m_pend_val;
   logic          t_req [2], t_we [2], t_lk [2];
   logic [AW-1:0] t_addr [2];
   logic [DW-1:0] t_wd [2];

   // Sampled DUT outputs of the latest step
   logic          s_g0, s_g1, s_rd, s_rv0, s_err;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_rdata;

   typedef struct {
      logic r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
      logic r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
      logic eg0; logic eg1;
   } vec_t;
   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic l1);
      t_req[0] = r0; t_we[0] = w0; t_addr[0] = a0; t_wd[0] = d0; t_lk[0] = l0;
      t_req[1] = r1; t_we[1] = w1; t_addr[1] = a1; t_wd[1] = d1; t_lk[1] = l1;
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.lock0 = l0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.lock1 = l1;
   endtask

   task automatic idle_in();
      set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic model_reset();
      m_last = 1; m_owner = -1; m_lcycle = 0; m_pend = -1; m_pend_val = '0;
   endtask

   // Called just after a rising edge with inputs already applied.
   task automatic step();
      int            win;
      logic          e_rd, e_wr, e_err;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_do, e_rdata;
      #2;
      if (m_owner < 0) begin
         if (t_req[0] && t_req[1]) win = (m_last == 1) ? 0 : 1;
         else if (t_req[0])        win = 0;
         else if (t_req[1])        win = 1;
         else                      win = -1;
      end else begin
         win = t_req[m_owner] ? m_owner : -1;
      end
      e_rd   = (win >= 0) && !t_we[win];
      e_wr   = (win >= 0) && t_we[win];
      e_addr = (win >= 0) ? t_addr[win] : '0;
      e_do   = e_wr ? t_wd[win] : '0;
      e_err  = (m_owner >= 0) && t_lk[m_owner] && (m_lcycle == MAXL);
      e_rdata = (m_pend >= 0) ? m_pend_val : '0;

      s_g0 = bus.gnt0; s_g1 = bus.gnt1; s_rd = bus.res_rd; s_addr = bus.res_addr;
      s_rv0 = bus.rvalid0; s_rdata = bus.rdata; s_err = bus.lock_err;

      chk("gnt0", bus.gnt0, win == 0);
      chk("gnt1", bus.gnt1, win == 1);
      chk("one_grant", bus.gnt0 & bus.gnt1, 0);
      chk("gnt_without_req", (bus.gnt0 & ~t_req[0]) | (bus.gnt1 & ~t_req[1]), 0);
      chk("res_rd", bus.res_rd, e_rd);
      chk("res_wr", bus.res_wr, e_wr);
      chk("res_addr", bus.res_addr, e_addr);
      chk("res_do", bus.res_do, e_do);
      chk("lock_err", bus.lock_err, e_err);
      chk("rvalid0", bus.rvalid0, m_pend == 0);
      chk("rvalid1", bus.rvalid1, m_pend == 1);
      chk("rdata", bus.rdata, e_rdata);

      @(posedge clk);
      #1;
      m_pend = -1;
      if (win >= 0) begin
         m_last = win;
         if (t_we[win]) begin
            shadow[t_addr[win]] = t_wd[win];
         end else begin
            m_pend     = win;
            m_pend_val = shadow[t_addr[win]];
         end
      end
      if (m_owner < 0) begin
         if (win >= 0 && t_lk[win]) begin
            m_owner  = win;
            m_lcycle = 1;
         end
      end else if (!t_lk[m_owner]) begin
         m_owner = -1;
      end else if (m_lcycle == MAXL) begin
         m_last  = m_owner;
         m_owner = -1;
      end else begin
         m_lcycle++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(1'b1, 1'b0, 14'h0081, '0, 1'b1, 1'b1, 1'b1, 14'h0002, 8'h33, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_res_rd", bus.res_rd, 0);
      chk("rst_res_wr", bus.res_wr, 0);
      chk("rst_res_addr", bus.res_addr, 0);
      chk("rst_res_do", bus.res_do, 0);
      chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_lock_err", bus.lock_err, 0);
      reset = 1'b0;
      idle_in();
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         shadow[i] = '0;
      end
      mem[14'h0081] = 8'h05;
      shadow[14'h0081] = 8'h05;
      idle_in();
      model_reset();

      // Single read straight after reset, data returns next cycle
      do_reset();
      set_in(1'b1, 1'b0, 14'h0081, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step();
      chk("r39_gnt0", s_g0, 1);
      chk("r39_res_rd", s_rd, 1);
      chk("r39_res_addr", s_addr, 14'h0081);
      idle_in();
      step();
      chk("r39_rvalid0", s_rv0, 1);
      chk("r39_rdata", s_rdata, 8'h05);

      // Contention alternates starting with port 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b1, 1'b0, 14'h0020, '0, 1'b0);
         step();
         chk("r40_alt_gnt0", s_g0, (i % 2) == 0);
      end

      // Directed table from a fresh reset
      vecs[0] = '{1'b1, 1'b0, 14'h0081, 8'h00, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 14'h0010, 8'h00, 1'b1, 1'b0, 14'h0020, 8'h00, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 14'h0010, 8'h00, 1'b1, 1'b0, 14'h0020, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h3FFF, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 14'h3FFF, 8'h00, 1'b1, 1'b0, 14'h0081, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 14'h0081, 8'hA5, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 14'h0081, 8'h00, 1'b1, 1'b0, 14'h0020, 8'h00, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 14'h0081, 8'h00, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0};
      vecs[9] = '{1'b1, 1'b1, 14'h0005, 8'h11, 1'b1, 1'b1, 14'h0006, 8'h22, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_in(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, 1'b0,
                vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, 1'b0);
         step();
         chk("vec_gnt0", s_g0, vecs[i].eg0);
         chk("vec_gnt1", s_g1, vecs[i].eg1);
      end
      idle_in();
      step();

      // Port 1 locks; port 0 stalls until the lock drops
      do_reset();
      set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 14'h3FFF, 8'h7F, 1'b1);
      step();
      chk("r41_wr_gnt1", s_g1, 1);
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 14'h3FFF, '0, 1'b0, 1'b1, 1'b0, 14'h0010, '0, 1'b1);
         step();
         chk("r41_stall_gnt0", s_g0, 0);
      end
      set_in(1'b1, 1'b0, 14'h3FFF, '0, 1'b0, 1'b1, 1'b0, 14'h0010, '0, 1'b0);
      step();
      chk("r41_unlock_gnt0", s_g0, 0);
      chk("r41_unlock_gnt1", s_g1, 1);
      set_in(1'b1, 1'b0, 14'h3FFF, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step();
      chk("r41_after_gnt0", s_g0, 1);
      idle_in();
      step();
      chk("r41_rdata", s_rdata, 8'h7F);

      // Lock timeout on port 0 with port 1 pending
      do_reset();
      set_in(1'b1, 1'b0, 14'h0081, '0, 1'b1, 1'b1, 1'b0, 14'h0020, '0, 1'b0);
      step();
      chk("r42_lock_gnt0", s_g0, 1);
      for (int k = 1; k <= MAXL; k++) begin
         step();
         chk("r42_lock_err", s_err, k == MAXL);
         chk("r42_locked_gnt1", s_g1, 0);
      end
      step();
      chk("r42_after_gnt1", s_g1, 1);
      idle_in();
      step();

      // Reset the cycle after a granted read drops the pending rvalid
      do_reset();
      set_in(1'b1, 1'b0, 14'h0081, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      step();
      reset = 1'b1;
      #1;
      chk("r43_rvalid0", bus.rvalid0, 0);
      chk("r43_rdata", bus.rdata, 0);
      chk("r43_gnt0", bus.gnt0, 0);
      do_reset();
      step();
      chk("r43_no_rvalid", s_rv0, 0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         set_in($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                DW'($urandom_range(0, 255)), $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                DW'($urandom_range(0, 255)), $urandom_range(0, 99) < 30);
         step();
      end
      idle_in();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
